// File: rtl/text_pixel_pipe_pkg.sv
// Shared constants and types for the text-mode pixel pipeline.
package text_pkg;

  localparam int CHAR_W      = 8;
  localparam int CHAR_H      = 16;
  localparam int H_CHARS_DEF = 80;
  localparam int V_CHARS_DEF = 30;
  localparam int COORD_W     = 10;
  localparam int CHAR_AW     = 12;
  localparam int FONT_AW     = 12;

  typedef logic [11:0] rgb444_t;

  // Per-pixel attributes that travel alongside the memory lookups.
  typedef struct packed {
    logic [3:0] glyphRow;
    logic [2:0] bitIdx;
    logic       cursorHit;
    logic       inRange;
    logic       videoOn;
    logic       hsync;
    logic       vsync;
  } pix_meta_t;

endpackage

// File: rtl/text_pixel_pipe_if.sv
// Bundle of timing sideband, memory ports, cursor/colour controls and pixel output.
interface text_pixel_pipe_if;
  import text_pkg::*;

  logic [COORD_W-1:0] pixel_x;
  logic [COORD_W-1:0] pixel_y;
  logic               video_on;
  logic               hsync_in;
  logic               vsync_in;
  logic [CHAR_AW-1:0] char_addr;
  logic [7:0]         char_code;
  logic [FONT_AW-1:0] font_addr;
  logic [7:0]         font_data;
  logic [6:0]         cursor_col;
  logic [4:0]         cursor_row;
  rgb444_t            fg_color;
  rgb444_t            bg_color;
  rgb444_t            rgb;
  logic               hsync_out;
  logic               vsync_out;
  logic               video_on_out;

  modport slave (
    input  pixel_x, pixel_y, video_on, hsync_in, vsync_in,
    input  char_code, font_data, cursor_col, cursor_row, fg_color, bg_color,
    output char_addr, font_addr, rgb, hsync_out, vsync_out, video_on_out
  );

  modport master (
    output pixel_x, pixel_y, video_on, hsync_in, vsync_in,
    output char_code, font_data, cursor_col, cursor_row, fg_color, bg_color,
    input  char_addr, font_addr, rgb, hsync_out, vsync_out, video_on_out
  );

endinterface

// File: rtl/text_pixel_pipe_cursor_blink.sv
// Cursor blink generator: counts vsync falling edges, toggles phase every BLINK_FRAMES.
module cursor_blink #(
  parameter int BLINK_FRAMES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync_in,
  output logic phase
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic             r_vsPrev;
  logic [CNT_W-1:0] r_count;
  logic             r_phase;
  logic             w_fall;

  assign w_fall = r_vsPrev & ~vsync_in;
  assign phase  = r_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsPrev <= 1'b0;
      r_count  <= '0;
      r_phase  <= 1'b0;
    end else begin
      r_vsPrev <= vsync_in;
      if (w_fall) begin
        if (r_count == CNT_W'(BLINK_FRAMES - 1)) begin
          r_count <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_count <= r_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/text_pixel_pipe.sv
// Text-mode pixel pipeline: cell address, glyph fetch and colour selection with a
// blinking underline cursor; rgb and sideband appear 3 cycles after the coordinates.
module text_pixel_pipe
  import text_pkg::*;
#(
  parameter int H_CHARS      = H_CHARS_DEF,
  parameter int V_CHARS      = V_CHARS_DEF,
  parameter int BLINK_FRAMES = 32
) (
  input logic clk,
  input logic rst_n,
  text_pixel_pipe_if.slave io_pix
);

  localparam int X_LIMIT = CHAR_W * H_CHARS;
  localparam int Y_LIMIT = CHAR_H * V_CHARS;

  logic [6:0]         w_col;
  logic [5:0]         w_row;
  logic               w_inRange;
  logic [CHAR_AW-1:0] w_charAddr;
  pix_meta_t          w_s1Next;
  logic               w_phase;
  logic               w_bit;
  rgb444_t            w_rgb;

  logic [CHAR_AW-1:0] r_charAddr;
  pix_meta_t          r_s1;
  pix_meta_t          r_s2;
  pix_meta_t          r_s3;
  rgb444_t            r_rgb;
  logic               r_hsync;
  logic               r_vsync;
  logic               r_videoOn;

  always_comb begin
    w_col      = io_pix.pixel_x[9:3];
    w_row      = io_pix.pixel_y[9:4];
    w_inRange  = (32'(io_pix.pixel_x) < X_LIMIT) && (32'(io_pix.pixel_y) < Y_LIMIT);
    w_charAddr = '0;
    if (w_inRange) begin
      w_charAddr = CHAR_AW'(w_row) * CHAR_AW'(H_CHARS) + CHAR_AW'(w_col);
    end
    w_s1Next           = '0;
    w_s1Next.glyphRow  = io_pix.pixel_y[3:0];
    w_s1Next.bitIdx    = io_pix.pixel_x[2:0];
    w_s1Next.cursorHit = (w_col == io_pix.cursor_col) && (w_row == {1'b0, io_pix.cursor_row});
    w_s1Next.inRange   = w_inRange;
    w_s1Next.videoOn   = io_pix.video_on;
    w_s1Next.hsync     = io_pix.hsync_in;
    w_s1Next.vsync     = io_pix.vsync_in;
  end

  // s2 lines up with char_code from the text RAM, s3 with font_data from the font ROM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_charAddr <= '0;
      r_s1       <= '0;
      r_s2       <= '0;
      r_s3       <= '0;
    end else begin
      r_charAddr <= w_charAddr;
      r_s1       <= w_s1Next;
      r_s2       <= r_s1;
      r_s3       <= r_s2;
    end
  end

  assign io_pix.char_addr = r_charAddr;
  assign io_pix.font_addr = {io_pix.char_code, r_s2.glyphRow};

  cursor_blink #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk     (clk),
    .rst_n   (rst_n),
    .vsync_in(io_pix.vsync_in),
    .phase   (w_phase)
  );

  // The cursor is drawn as an inverted underline on the bottom two glyph rows.
  always_comb begin
    w_bit = io_pix.font_data[3'd7 - r_s3.bitIdx];
    if (r_s3.cursorHit && w_phase && (r_s3.glyphRow >= 4'd14)) begin
      w_bit = ~w_bit;
    end
    w_rgb = 12'h000;
    if (r_s3.videoOn && r_s3.inRange) begin
      w_rgb = w_bit ? io_pix.fg_color : io_pix.bg_color;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb     <= '0;
      r_hsync   <= 1'b0;
      r_vsync   <= 1'b0;
      r_videoOn <= 1'b0;
    end else begin
      r_rgb     <= w_rgb;
      r_hsync   <= r_s3.hsync;
      r_vsync   <= r_s3.vsync;
      r_videoOn <= r_s3.videoOn;
    end
  end

  assign io_pix.rgb          = r_rgb;
  assign io_pix.hsync_out    = r_hsync;
  assign io_pix.vsync_out    = r_vsync;
  assign io_pix.video_on_out = r_videoOn;

endmodule

// File: tb/tb_text_pixel_pipe.sv
// Scoreboard bench for text_pixel_pipe: random and directed pixels against a
// coordinate-level model of the screen, memories and cursor blink.
module tb_text_pixel_pipe;
  import text_pkg::*;

  localparam int H_CHARS      = 80;
  localparam int V_CHARS      = 30;
  localparam int BLINK_FRAMES = 32;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       hs;
    logic       vs;
    logic [6:0] ccol;
    logic [4:0] crow;
  } pix_t;

  typedef struct {
    bit          chkFont;
    logic [11:0] addr;
    logic [11:0] font;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        von;
    int          step;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  text_pixel_pipe_if bus();

  text_pixel_pipe #(
    .H_CHARS     (H_CHARS),
    .V_CHARS     (V_CHARS),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_pix(bus.slave)
  );

  logic [7:0] textRam [4096];
  logic [7:0] fontRom [4096];

  // Synchronous-read memories: data valid one cycle after the address.
  always @(posedge clk) begin
    bus.char_code <= textRam[bus.char_addr];
    bus.font_data <= fontRom[bus.font_addr];
  end

  pix_t pend[$];
  exp_t expQ[$];
  pix_t prevPix;
  bit   havePrev;
  int   falls;
  bit   prevVs;
  bit   lastVs;
  int   stepNo;
  int   checks;
  int   failures;

  function automatic bit inScreen(pix_t p);
    return (int'(p.x) < 8 * H_CHARS) && (int'(p.y) < 16 * V_CHARS);
  endfunction

  function automatic logic [11:0] addrOf(pix_t p);
    if (!inScreen(p)) return 12'd0;
    return 12'((int'(p.y) / 16) * H_CHARS + int'(p.x) / 8);
  endfunction

  function automatic logic [11:0] expRgb(pix_t p, bit ph, logic [11:0] fg, logic [11:0] bg);
    logic [7:0] code;
    logic [7:0] row;
    int         glyph;
    bit         pixOn;
    bit         hit;
    if (!p.von || !inScreen(p)) return 12'h000;
    glyph = int'(p.y) % 16;
    code  = textRam[addrOf(p)];
    row   = fontRom[int'(code) * 16 + glyph];
    pixOn = row[7 - (int'(p.x) % 8)];
    hit   = (int'(p.x) / 8 == int'(p.ccol)) && (int'(p.y) / 16 == int'(p.crow));
    if (hit && ph && glyph >= 14) pixOn = !pixOn;
    return pixOn ? fg : bg;
  endfunction

  function automatic pix_t mkPix(int x, int y, bit von, bit hs, bit vs, int ccol, int crow);
    pix_t p;
    p.x = 10'(x); p.y = 10'(y); p.von = von; p.hs = hs; p.vs = vs;
    p.ccol = 7'(ccol); p.crow = 5'(crow);
    return p;
  endfunction

  function automatic pix_t randPix(int ccol, int crow);
    int sel;
    int x;
    int y;
    bit vs;
    sel = $urandom_range(0, 9);
    if (sel < 2) begin
      x = ccol * 8 + $urandom_range(0, 7);
      y = crow * 16 + $urandom_range(12, 15);
    end else if (sel < 8) begin
      x = $urandom_range(0, 639);
      y = $urandom_range(0, 479);
    end else begin
      x = $urandom_range(0, 1023);
      y = $urandom_range(0, 1023);
    end
    vs = ($urandom_range(0, 2) == 0) ? !lastVs : lastVs;
    lastVs = vs;
    return mkPix(x, y, $urandom_range(0, 9) != 0, 1'($urandom), vs, ccol, crow);
  endfunction

  task automatic clearModel();
    pend.delete();
    expQ.delete();
    havePrev = 0;
    falls    = 0;
    prevVs   = 0;
  endtask

  task automatic drive(pix_t p, logic [11:0] fg, logic [11:0] bg);
    bus.pixel_x    = p.x;
    bus.pixel_y    = p.y;
    bus.video_on   = p.von;
    bus.hsync_in   = p.hs;
    bus.vsync_in   = p.vs;
    bus.cursor_col = p.ccol;
    bus.cursor_row = p.crow;
    bus.fg_color   = fg;
    bus.bg_color   = bg;
  endtask

  // Expected outputs for the edge that samples this step's inputs: char_addr of
  // this pixel, font_addr of the previous one, rgb of the one three steps back.
  task automatic modelStep(pix_t cur, logic [11:0] fg, logic [11:0] bg);
    exp_t e;
    pix_t old;
    bit   ph;
    ph        = ((falls / BLINK_FRAMES) % 2) == 1;
    e.step    = stepNo;
    e.addr    = addrOf(cur);
    e.chkFont = havePrev;
    e.font    = havePrev ? {textRam[addrOf(prevPix)], prevPix.y[3:0]} : 12'h000;
    pend.push_back(cur);
    if (pend.size() > 3) begin
      old   = pend.pop_front();
      e.rgb = expRgb(old, ph, fg, bg);
      e.hs  = old.hs;
      e.vs  = old.vs;
      e.von = old.von;
    end else begin
      e.rgb = 12'h000;
      e.hs  = 1'b0;
      e.vs  = 1'b0;
      e.von = 1'b0;
    end
    expQ.push_back(e);
    if (prevVs && !cur.vs) falls++;
    prevVs   = cur.vs;
    prevPix  = cur;
    havePrev = 1;
    stepNo++;
  endtask

  task automatic applyStimulus(pix_t p, logic [11:0] fg, logic [11:0] bg);
    @(negedge clk);
    #2;
    drive(p, fg, bg);
    modelStep(p, fg, bg);
  endtask

  task automatic doReset(int n, pix_t first, logic [11:0] fg, logic [11:0] bg);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    clearModel();
    repeat (n) begin
      @(negedge clk);
      #2;
      drive(randPix($urandom_range(0, 79), $urandom_range(0, 29)), 12'($urandom), 12'($urandom));
    end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    drive(first, fg, bg);
    modelStep(first, fg, bg);
  endtask

  task automatic checkVal(string name, int step, logic [11:0] act, logic [11:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s step=%0d actual=%h expected=%h", name, step, act, req);
    end
  endtask

  task automatic checkOutput(exp_t e);
    checkVal("char_addr", e.step, bus.char_addr, e.addr);
    if (e.chkFont) checkVal("font_addr", e.step, bus.font_addr, e.font);
    checkVal("rgb", e.step, bus.rgb, e.rgb);
    checkVal("hsync_out", e.step, {11'd0, bus.hsync_out}, {11'd0, e.hs});
    checkVal("vsync_out", e.step, {11'd0, bus.vsync_out}, {11'd0, e.vs});
    checkVal("video_on_out", e.step, {11'd0, bus.video_on_out}, {11'd0, e.von});
  endtask

  // Monitor: outputs forced to zero while in reset, otherwise one scoreboard entry per cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      checkVal("reset_rgb", stepNo, bus.rgb, 12'h000);
      checkVal("reset_char_addr", stepNo, bus.char_addr, 12'h000);
      checkVal("reset_sideband", stepNo,
               {9'd0, bus.hsync_out, bus.vsync_out, bus.video_on_out}, 12'h000);
    end else if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput(e);
    end
  end

  initial begin
    int ccol;
    int crow;
    checks   = 0;
    failures = 0;
    stepNo   = 0;
    lastVs   = 0;
    clearModel();
    for (int i = 0; i < 4096; i++) begin
      textRam[i] = 8'($urandom);
      fontRom[i] = 8'($urandom);
    end
    textRam[81]      = 8'h21;
    fontRom[12'h210] = 8'h80;
    fontRom[12'h21F] = 8'h00;

    $display("[TB] reset with random inputs");
    doReset(4, mkPix(8, 16, 1, 1, 0, 127, 31), 12'hFFF, 12'h00F);

    $display("[TB] directed cell lookup and colour select");
    applyStimulus(mkPix(9, 16, 1, 0, 1, 127, 31), 12'hFFF, 12'h00F);
    applyStimulus(mkPix(700, 16, 1, 1, 1, 127, 31), 12'hFFF, 12'h00F);
    applyStimulus(mkPix(8, 16, 0, 0, 0, 127, 31), 12'hFFF, 12'h00F);
    applyStimulus(mkPix(639, 479, 1, 1, 0, 127, 31), 12'hFFF, 12'h00F);
    applyStimulus(mkPix(640, 0, 1, 0, 0, 127, 31), 12'hFFF, 12'h00F);
    applyStimulus(mkPix(0, 480, 1, 1, 0, 127, 31), 12'hFFF, 12'h00F);
    applyStimulus(mkPix(0, 0, 1, 0, 0, 127, 31), 12'h123, 12'h456);
    repeat (4) applyStimulus(mkPix(8, 16, 1, 0, 0, 127, 31), 12'hFFF, 12'h00F);

    $display("[TB] ten vsync falls then reset");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(mkPix(8, 31, 1, 0, 1, 1, 1), 12'hFFF, 12'h00F);
      applyStimulus(mkPix(8, 31, 1, 0, 0, 1, 1), 12'hFFF, 12'h00F);
    end
    doReset(1, mkPix(8, 31, 1, 0, 0, 1, 1), 12'hFFF, 12'h00F);

    $display("[TB] cursor blink over 70 frames");
    for (int i = 0; i < 70; i++) begin
      applyStimulus(mkPix(8, 31, 1, 0, 1, 1, 1), 12'hFFF, 12'h00F);
      applyStimulus(mkPix(8, 31, 1, 0, 0, 1, 1), 12'hFFF, 12'h00F);
    end
    lastVs = 0;

    $display("[TB] random traffic");
    ccol = $urandom_range(0, 79);
    crow = $urandom_range(0, 29);
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        ccol = $urandom_range(0, 79);
        crow = $urandom_range(0, 29);
      end
      if (i == 1500) begin
        doReset(2, randPix(ccol, crow), 12'($urandom), 12'($urandom));
      end else begin
        applyStimulus(randPix(ccol, crow), 12'($urandom), 12'($urandom));
      end
    end

    repeat (3) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/text_pixel_pipe.md
TEXT_PIXEL_PIPE -- requirements
Module: text_pixel_pipe

Interface
REQ-001 SHALL have parameter H_CHARS, default 80, meaning characters per text row.
REQ-002 SHALL have parameter V_CHARS, default 30, meaning text rows per screen.
REQ-003 SHALL have parameter BLINK_FRAMES, default 32, meaning frames per cursor blink half-period.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 pixel_x, pixel_y  input  10 each  current pixel coordinates from the video timing block.
REQ-007 video_on, hsync_in, vsync_in  input  1 each  timing-block sideband.
REQ-008 char_addr  output  12  text-RAM address, row*H_CHARS+col.
REQ-009 char_code  input  8  text-RAM read data, valid one cycle after char_addr.
REQ-010 font_addr  output  12  Font_ROM address, {char_code, glyph_row[3:0]}.
REQ-011 font_data  input  8  Font_ROM row data, valid one cycle after font_addr; bit 7 is the leftmost pixel.
REQ-012 cursor_col  input  7; cursor_row  input  5  cursor character cell.
REQ-013 fg_color, bg_color  input  12 each  RGB444 colours.
REQ-014 rgb  output  12  pixel colour.
REQ-015 hsync_out, vsync_out, video_on_out  output  1 each  sideband aligned with rgb.

Function
REQ-016 Cells SHALL be 8x16 pixels: col = pixel_x[9:3], glyph_row = pixel_y[3:0], bit index = pixel_x[2:0], text row = pixel_y[9:4].
REQ-017 Stage 1 SHALL register char_addr, glyph_row, bit index, cursor-hit flag, video_on, hsync_in and vsync_in on the edge that samples pixel_x and pixel_y (edge E0).
REQ-018 Stage 2 SHALL delay glyph_row, bit index, cursor-hit and sideband by one more cycle.
REQ-019 font_addr SHALL be combinational from char_code and the stage-2 glyph_row.
REQ-020 Stage 3 SHALL register rgb and the sideband outputs at E3, giving a total latency of exactly 3 cycles from sampled coordinates to rgb.
REQ-021 The selected pixel bit SHALL be font_data[7 - bit index].
REQ-022 rgb SHALL be fg_color if the bit is 1 and bg_color if it is 0.
REQ-023 When the cursor-hit flag is set, the blink phase is 1 and glyph_row is 14 or 15, the selected bit SHALL be inverted before colour selection.
REQ-024 cursor-hit SHALL be set when col == cursor_col and text row == cursor_row.
REQ-025 Delayed video_on = 0, pixel_x >= 8*H_CHARS, or pixel_y >= 16*V_CHARS SHALL force rgb = 12'h000.
REQ-026 For any out-of-range coordinate, char_addr SHALL be forced to 0.
REQ-027 Blink counter: SHALL increment on each vsync_in falling edge.
REQ-028 Blink counter: at BLINK_FRAMES-1 it SHALL wrap to 0 and toggle the blink phase.
REQ-029 Blink counter: detection SHALL use a registered copy of vsync_in.
REQ-030 char_addr arithmetic SHALL be 12-bit; the maximum in-range value is 2399, so no overflow occurs.
REQ-031 Pipeline registers SHALL update every cycle, with no stall.

Reset
REQ-032 rst_n low SHALL asynchronously clear the following to 0: char_addr, every pipeline register, rgb, hsync_out, vsync_out, video_on_out, the blink counter, the blink phase and the vsync history.
REQ-033 Reset asserted mid-frame SHALL flush in-flight pixels; outputs SHALL resume valid 3 cycles after deassertion.

Structure
REQ-034 Package text_pkg SHALL hold CHAR_W=8, CHAR_H=16, the H_CHARS/V_CHARS defaults, the RGB444 typedef and address-width constants.
REQ-035 The blink counter and phase SHALL be a sub-module named cursor_blink (inputs clk, rst_n, vsync_in; output phase).

Verification
REQ-036 Hold rst_n=0 with random inputs -> rgb=0, char_addr=0, all sideband outputs 0.
REQ-037 Drive pixel_x=8, pixel_y=16, video_on=1 -> char_addr=81 after 1 cycle; with char_code=8'h21 returned -> font_addr=12'h210.
REQ-038 Drive font_data=8'h80, bit index 0, fg=12'hFFF, bg=12'h00F -> rgb=12'hFFF exactly 3 cycles after coordinates; bit index 1 -> 12'h00F.
REQ-039 Drive video_on=0, or pixel_x=700, with font_data=8'hFF -> rgb=12'h000; sideband still delayed by exactly 3 cycles.
REQ-040 Set cursor (1,1), pixel_y=31 (row 15), font_data=8'h00, and apply 32 vsync falling edges -> rgb switches bg->fg; after 32 more edges it returns to bg.
REQ-041 Assert rst_n for 1 cycle after 10 vsync falling edges -> blink counter is 0, the next 3 rgb values are 0, and then normal output follows.
